ram_bist_ctrl: RTL
==================

Name: ram_bist_ctrl

Overview:
March-style built-in self-test controller that sits directly upstream of the team's 16x8 sync_RAM. It drives the RAM's en/we/addr/din pins and checks the RAM's dout. On a start pulse it runs a 4-element march (W / RW / RW / R) over every address using a background pattern and its complement. It reports pass/fail plus the first failing address and data, and is used for power-on and debug memory checks.

Parameters:
ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W locations
DATA_W, 8, RAM data width
BG_PATTERN, 8'h55, background pattern; complement is ~BG_PATTERN

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse; sampled only in IDLE or DONE
ram_en  output  1  to RAM en
ram_we  output  1  to RAM we
ram_addr  output  ADDR_W  to RAM addr
ram_din  output  DATA_W  to RAM din
ram_dout  input  DATA_W  from RAM dout; valid the cycle after a read is issued
busy  output  1  high from the cycle after start until the test ends
done  output  1  level; high in DONE until the next start or rst
pass  output  1  valid when done=1; 1 means no mismatch
fail_addr  output  ADDR_W  address of the first mismatch
fail_exp  output  DATA_W  expected data at the first mismatch
fail_got  output  DATA_W  ram_dout captured at the first mismatch

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, pass=0, fail_*=0; ram_en=0, ram_we=0, ram_addr=0, ram_din=0; chk_pend=0. RAM contents are not touched.
- ram_* outputs are combinational decodes of state, address counter and phase. ram_en=0 in IDLE, FLUSH and DONE.
- States and per-cycle operation (one RAM op per cycle, BG=BG_PATTERN):
  - IDLE: if start, go to M0 with addr=0. Otherwise stay.
  - M0 (up): write BG to addr 0..DEPTH-1. 16 cycles. Then M1 with addr=0, phase=0.
  - M1 (up): per address, phase0 = read (exp BG), then phase1 = write ~BG. 32 cycles. Then M2 with addr=DEPTH-1.
  - M2 (down): per address, phase0 = read (exp ~BG), then phase1 = write BG. 32 cycles. Then M3 with addr=DEPTH-1.
  - M3 (down): read (exp BG) at addr DEPTH-1..0. 16 cycles. Then FLUSH.
  - FLUSH: one cycle; compares the final read. Then DONE.
  - DONE: done=1, busy=0. If start, clear pass/fail_*/done and go to M0.
- Clean-run latency: start high at edge E0 puts M0 at addr 0 in the next cycle. busy stays high for 97 cycles (96 op cycles + FLUSH). done=1 starting in cycle 98.
- Compare pipeline:
  - Issuing a read sets chk_pend=1 and latches exp_q and addr_q.
  - In the next cycle, if chk_pend and ram_dout != exp_q, this is a mismatch.
  - chk_pend clears unless another read is issued that cycle. Back-to-back reads in M3 compare every cycle.
- First mismatch handling:
  - At the end of that cycle: fail_addr=addr_q, fail_exp=exp_q, fail_got=ram_dout, pass=0, next state=DONE.
  - The op already issued in the mismatch cycle still occurs. No further RAM access follows.
  - Only the first mismatch is recorded.
- pass is set to 1 on entering DONE only if no mismatch occurred. pass=0 whenever done=0.
- Address counter wraps: it increments in up elements and decrements in down elements. It advances only after phase1 in M1/M2, and every cycle in M0/M3.
- start while busy is ignored. start and rst together: rst wins.
- rst mid-test: immediate return to IDLE with reset values. A subsequent start restarts from M0.

Test Plan:
- Clean RAM, BG=8'h55, start pulse -> busy high exactly 97 cycles; done=1, pass=1, fail_*=0; every address ends holding 8'h55.
- Bus trace, clean run -> cycles 1-16 we=1, din=55, addr 0..F; M1 alternates read/write ~55=AA up; M2 alternates read/write 55 starting at addr F; M3 reads F..0.
- RAM bit 0 stuck-at-1 at addr 4 (bench forces the model) -> first mismatch in M1 read of addr 4; fail_addr=4, fail_exp=55, fail_got=55 with bit0 forced to 1 (=55, no fail), so force bit1 instead: fail_got=57; done=1, pass=0, busy falls early.
- Stuck-at-0 bit7 at addr F -> fail in M2 read of addr F: fail_exp=AA, fail_got=2A, pass=0.
- rst asserted during M2 -> all outputs return to 0 asynchronously; start afterwards -> full clean run, pass=1.
- start pulsed while busy -> no effect, 97-cycle timing unchanged; start in DONE -> done/pass clear next cycle and the test reruns.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// March BIST controller for the 16x8 sync RAM: W / RW / RW / R march with a
// background pattern and its complement, recording the first failing read.
module ram_bist_ctrl #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] BG_PATTERN = 'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_FLUSH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              chk_pend_q, chk_pend_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;

  logic              rd_issue;
  logic [DATA_W-1:0] rd_exp;
  logic              mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      chk_pend_q  <= 1'b0;
      exp_q       <= '0;
      rd_addr_q   <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      chk_pend_q  <= chk_pend_d;
      exp_q       <= exp_d;
      rd_addr_q   <= rd_addr_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    exp_d       = exp_q;
    rd_addr_d   = rd_addr_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_din     = '0;
    rd_issue    = 1'b0;
    rd_exp      = BG_PATTERN;

    // A pending compare left over from the mismatch cycle must not count in DONE.
    mismatch = chk_pend_q && (ram_dout != exp_q) &&
               (state_q != S_IDLE) && (state_q != S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_M0;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end
      S_M0: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        ram_din = BG_PATTERN;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_MAX) begin
          state_d = S_M1;
          phase_d = 1'b0;
        end
      end
      S_M1: begin
        ram_en = 1'b1;
        if (!phase_q) begin
          rd_issue = 1'b1;
          rd_exp   = BG_PATTERN;
          phase_d  = 1'b1;
        end else begin
          ram_we  = 1'b1;
          ram_din = ~BG_PATTERN;
          phase_d = 1'b0;
          cnt_d   = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_MAX) begin
            state_d = S_M2;
            cnt_d   = ADDR_MAX;
          end
        end
      end
      S_M2: begin
        ram_en = 1'b1;
        if (!phase_q) begin
          rd_issue = 1'b1;
          rd_exp   = ~BG_PATTERN;
          phase_d  = 1'b1;
        end else begin
          ram_we  = 1'b1;
          ram_din = BG_PATTERN;
          phase_d = 1'b0;
          cnt_d   = cnt_q - ADDR_W'(1);
          if (cnt_q == '0) state_d = S_M3;
        end
      end
      S_M3: begin
        ram_en   = 1'b1;
        rd_issue = 1'b1;
        rd_exp   = BG_PATTERN;
        cnt_d    = cnt_q - ADDR_W'(1);
        if (cnt_q == '0) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_DONE;
        pass_d  = 1'b1;
      end
      S_DONE: begin
        if (start) begin
          state_d     = S_M0;
          cnt_d       = '0;
          phase_d     = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    chk_pend_d = rd_issue;
    if (rd_issue) begin
      exp_d     = rd_exp;
      rd_addr_d = cnt_q;
    end

    if (mismatch) begin
      state_d     = S_DONE;
      pass_d      = 1'b0;
      fail_addr_d = rd_addr_q;
      fail_exp_d  = exp_q;
      fail_got_d  = ram_dout;
    end
  end

  assign ram_addr  = ram_en ? cnt_q : '0;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule
